// File: rtl/capture_buffer.sv
// Trigger-aligned sample capture into a circular RAM.
// The captured window is streamed out oldest-first over valid/ready.
module capture_buffer #(
  parameter int DATA_WIDTH = 33,
  parameter int ADDR_WIDTH = 8,
  parameter int PRE_TRIG = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  trigger,
  output logic                  busy,
  output logic                  triggered,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done
);
  localparam int D = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PT = ADDR_WIDTH'(PRE_TRIG);
  localparam logic [ADDR_WIDTH-1:0] PT_M1 = ADDR_WIDTH'(PRE_TRIG - 1);
  localparam logic [ADDR_WIDTH-1:0] NPOST = ADDR_WIDTH'(D - 1 - PRE_TRIG);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0] NRD = (ADDR_WIDTH+1)'(D);
  localparam logic [ADDR_WIDTH:0] NRD_M1 = (ADDR_WIDTH+1)'(D - 1);
  localparam logic [ADDR_WIDTH:0] RONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, READ} state_t;

  state_t state;
  logic [DATA_WIDTH-1:0] mem [D];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [ADDR_WIDTH-1:0] fill;
  logic [ADDR_WIDTH-1:0] post;
  logic [ADDR_WIDTH:0]   rcnt;
  logic q_vld;
  logic q_last;
  logic wr_en;
  logic out_adv;
  logic rd_en;
  logic fire_last;

  always_comb begin
    wr_en = (state == PRE) || (state == WAIT) || (state == POST);
    out_adv = !rd_valid || rd_ready;
    rd_en = (state == READ) && (rcnt != NRD) && (!q_vld || out_adv);
    fire_last = rd_valid && rd_ready && rd_last;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wp] <= data;
    if (rd_en) ram_q <= mem[rp];
  end

  // ram_q is a one-deep stage in front of the output register; it only
  // reloads when it is empty or draining, so a stall freezes both.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      fill <= '0;
      post <= '0;
      rcnt <= '0;
      q_vld <= 1'b0;
      q_last <= 1'b0;
      busy <= 1'b0;
      triggered <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
      rd_data <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en) wp <= wp + ONE;
      unique case (state)
        IDLE: begin
          if (arm) begin
            state <= (PRE_TRIG == 0) ? WAIT : PRE;
            busy <= 1'b1;
            wp <= '0;
            fill <= '0;
            post <= '0;
            rcnt <= '0;
            q_vld <= 1'b0;
            rd_valid <= 1'b0;
            rd_last <= 1'b0;
          end
        end
        PRE: begin
          fill <= fill + ONE;
          if (fill == PT_M1) state <= WAIT;
        end
        WAIT: begin
          if (trigger) begin
            rp <= wp - PT;
            post <= NPOST;
            triggered <= 1'b1;
            state <= (NPOST == '0) ? READ : POST;
          end
        end
        POST: begin
          post <= post - ONE;
          if (post == ONE) state <= READ;
        end
        READ: begin
          if (rd_en) begin
            rp <= rp + ONE;
            rcnt <= rcnt + RONE;
            q_vld <= 1'b1;
            q_last <= (rcnt == NRD_M1);
          end else if (out_adv) begin
            q_vld <= 1'b0;
          end
          if (out_adv) begin
            rd_valid <= q_vld;
            rd_last <= q_vld && q_last;
            if (q_vld) rd_data <= ram_q;
          end
          if (fire_last) begin
            state <= IDLE;
            busy <= 1'b0;
            triggered <= 1'b0;
            rd_valid <= 1'b0;
            rd_last <= 1'b0;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (wr_en && !arm) begin
        state <= IDLE;
        busy <= 1'b0;
        triggered <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_capture_buffer.sv
// Bench for capture_buffer: D=16 with PRE_TRIG=4 (dut0) and PRE_TRIG=0 (dut1).
// Expected windows come from a log of every sample written.
module tb_capture_buffer;
  localparam int DW = 33;
  localparam int D = 16;

  logic clock;
  logic reset_n;
  logic arm;
  logic trigger;
  logic rd_ready;
  logic [DW-1:0] data;
  logic busy0, trig0, valid0, last0, done0;
  logic busy1, trig1, valid1, last1, done1;
  logic [DW-1:0] rdat0, rdat1;
  logic sel;
  logic busy_s, trig_s, valid_s, last_s, done_s;
  logic [DW-1:0] rdat_s;
  int ncmp;
  int nerr;

  capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .PRE_TRIG(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .arm(arm), .data(data),
    .trigger(trigger), .busy(busy0), .triggered(trig0),
    .rd_valid(valid0), .rd_ready(rd_ready), .rd_data(rdat0),
    .rd_last(last0), .done(done0)
  );

  capture_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(4), .PRE_TRIG(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .arm(arm), .data(data),
    .trigger(trigger), .busy(busy1), .triggered(trig1),
    .rd_valid(valid1), .rd_ready(rd_ready), .rd_data(rdat1),
    .rd_last(last1), .done(done1)
  );

  assign busy_s = sel ? busy1 : busy0;
  assign trig_s = sel ? trig1 : trig0;
  assign valid_s = sel ? valid1 : valid0;
  assign last_s = sel ? last1 : last0;
  assign done_s = sel ? done1 : done0;
  assign rdat_s = sel ? rdat1 : rdat0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy_s, 0);
    chk({tag, "_trig"}, trig_s, 0);
    chk({tag, "_valid"}, valid_s, 0);
    chk({tag, "_last"}, last_s, 0);
    chk({tag, "_done"}, done_s, 0);
    chk({tag, "_data"}, rdat_s, 0);
  endtask

  task automatic do_reset(input bit s);
    sel = s;
    reset_n = 1'b0;
    arm = 1'b0;
    trigger = 1'b0;
    rd_ready = 1'b0;
    data = '0;
    @(negedge clock);
    @(negedge clock);
    chk_idle("reset");
    reset_n = 1'b1;
  endtask

  // One capture: triggers at write indices tg0/tg1, optional stall at a
  // beat, random data/ready, or a reset injected at beat rst_beat.
  task automatic run(input bit s, input int pre, input int tg0,
                     input int tg1, input int stall_beat, input bit rnd,
                     input int rst_beat);
    logic [DW-1:0] hist[$];
    logic [DW-1:0] d;
    logic [DW-1:0] hdata;
    int n, t, total, beat, cyc, stalls;
    bit held, rdy;
    do_reset(s);
    arm = 1'b1;
    @(negedge clock);
    chk("arm_busy", busy_s, 1);
    chk("arm_trig", trig_s, 0);
    n = 0;
    t = -1;
    total = -1;
    while (total < 0 || n < total) begin
      if (n > 200) begin
        chk("trigger_accept_timeout", 0, 1);
        return;
      end
      d = rnd ? DW'({$urandom, $urandom}) : DW'(n);
      data = d;
      trigger = (n == tg0) || (n == tg1);
      hist.push_back(d);
      if (t < 0 && trigger && n >= pre) begin
        t = n;
        total = n + D - pre;
      end
      @(negedge clock);
      chk("cap_triggered", trig_s, (t >= 0) ? 1 : 0);
      chk("cap_valid", valid_s, 0);
      n++;
    end
    trigger = 1'b0;
    beat = 0;
    cyc = 0;
    stalls = 0;
    held = 1'b0;
    hdata = '0;
    while (beat < D) begin
      if (cyc > 200) begin
        chk("readout_timeout", beat, D);
        return;
      end
      if (cyc < 2) chk("lat_low", valid_s, 0);
      if (cyc == 2) chk("lat_rise", valid_s, 1);
      chk("rd_done_low", done_s, 0);
      if (held) begin
        chk("hold_valid", valid_s, 1);
        chk("hold_data", rdat_s, hdata);
      end
      if (valid_s) begin
        chk("rd_data", rdat_s, hist[t - pre + beat]);
        chk("rd_last", last_s, (beat == D - 1) ? 1 : 0);
      end
      if (rst_beat >= 0 && beat == rst_beat && valid_s) begin
        reset_n = 1'b0;
        rd_ready = 1'b0;
        @(negedge clock);
        chk_idle("midread_reset");
        reset_n = 1'b1;
        arm = 1'b0;
        @(negedge clock);
        chk("post_reset_busy", busy_s, 0);
        chk("post_reset_valid", valid_s, 0);
        return;
      end
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else if (beat == stall_beat && stalls < 3) rdy = 1'b0;
      else rdy = 1'b1;
      if (valid_s && !rdy) stalls++;
      rd_ready = rdy;
      held = valid_s && !rdy;
      hdata = rdat_s;
      if (valid_s && rdy) beat++;
      @(negedge clock);
      cyc++;
    end
    if (stall_beat >= 0) chk("stall_cycles", stalls, 3);
    chk("end_valid", valid_s, 0);
    chk("end_done", done_s, 1);
    chk("end_busy", busy_s, 0);
    chk("end_trig", trig_s, 0);
    @(negedge clock);
    chk("rearm_done", done_s, 0);
    chk("rearm_busy", busy_s, 1);
    arm = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic abort_test();
    do_reset(1'b0);
    arm = 1'b1;
    @(negedge clock);
    for (int n = 0; n <= 13; n++) begin
      data = DW'(n);
      trigger = (n == 10);
      @(negedge clock);
    end
    chk("abort_trig_before", trig_s, 1);
    arm = 1'b0;
    trigger = 1'b0;
    rd_ready = 1'b1;
    @(negedge clock);
    chk("abort_busy", busy_s, 0);
    chk("abort_trig", trig_s, 0);
    for (int i = 0; i < 20; i++) begin
      chk("abort_valid", valid_s, 0);
      chk("abort_done", done_s, 0);
      @(negedge clock);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ncmp = 0;
    nerr = 0;
    sel = 1'b0;
    reset_n = 1'b0;
    arm = 1'b0;
    trigger = 1'b0;
    rd_ready = 1'b0;
    data = '0;
    run(1'b0, 4, 10, -1, -1, 1'b0, -1);
    run(1'b0, 4, 2, 5, -1, 1'b0, -1);
    run(1'b0, 4, 20, -1, -1, 1'b0, -1);
    run(1'b0, 4, 10, -1, 3, 1'b0, -1);
    abort_test();
    run(1'b0, 4, 10, -1, -1, 1'b0, 7);
    run(1'b1, 0, 0, -1, -1, 1'b0, -1);
    for (int i = 0; i < 6; i++)
      run(1'b0, 4, $urandom_range(0, 40), $urandom_range(4, 40), -1, 1'b1, -1);
    for (int i = 0; i < 2; i++)
      run(1'b1, 0, $urandom_range(0, 40), $urandom_range(0, 40), -1, 1'b1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
